// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_pkg
// Brief    : Shared field type, range limits and a seconds-saturation helper
//            for the seconds, minutes and hours stages of the digital clock.
// Revision : 1.0 - initial release
// ============================================================================
package clk_pkg;

    typedef logic [7:0] time_field_t;

    localparam time_field_t SEC_MAX = 8'd59;
    localparam time_field_t MIN_MAX = 8'd59;
    localparam time_field_t HR_MAX  = 8'd23;

    // A preset above the field range is clamped to the top value.
    function automatic time_field_t sat_sec(input time_field_t v);
        return (v > SEC_MAX) ? SEC_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_count_sec_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_count_sec_if
// Brief    : Control and status bundle of the seconds stage. The blink status
//            line exists only when CLK_SEC_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_count_sec_if;
    import clk_pkg::*;

    logic        rst_counters;
    logic        run;
    logic        set_sec_valid;
    time_field_t set_sec_val;
    logic        tick_sec;
    logic        count_up_min;
    time_field_t secs;
`ifdef CLK_SEC_BLINK_EN
    logic        blink;
`endif

    modport master (
        output rst_counters, run, set_sec_valid, set_sec_val,
`ifdef CLK_SEC_BLINK_EN
        input  blink,
`endif
        input  tick_sec, count_up_min, secs
    );

    modport slave (
        input  rst_counters, run, set_sec_valid, set_sec_val,
`ifdef CLK_SEC_BLINK_EN
        output blink,
`endif
        output tick_sec, count_up_min, secs
    );

endinterface
`default_nettype wire

// File: rtl/clk_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : clk_prescaler
// Brief    : Modulo-DIV cycle counter that holds while en=0 and emits a
//            one-cycle tick on its last count.
// Revision : 1.0 - initial release
// ============================================================================
module clk_prescaler #(
    parameter int DIV = 8
) (
    input  wire logic                   CLK,
    input  wire logic                   rst,
    input  wire logic                   clr,
    input  wire logic                   en,
    output logic                        tick,
    output logic [$clog2(DIV)-1:0]      pre
);

    localparam int                 c_pre_w = $clog2(DIV);
    localparam logic [c_pre_w-1:0] c_last  = c_pre_w'(DIV - 1);

    logic [c_pre_w-1:0] r_pre;

    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= (r_pre == c_last) ? '0 : r_pre + 1'b1;
        end
    end

    // A clear in the terminal cycle swallows that tick rather than deferring it.
    assign tick = en & ~rst & ~clr & (r_pre == c_last);
    assign pre  = r_pre;

endmodule
`default_nettype wire

// File: rtl/clk_count_sec.sv
`default_nettype none
// ============================================================================
// Module   : clk_count_sec
// Brief    : Seconds stage: divides CLK to the seconds tick, counts 0..59 and
//            pulses count_up_min on the wrap. Optional colon-LED blink output
//            under macro CLK_SEC_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clk_count_sec
    import clk_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1
) (
    input  wire logic       CLK,
    input  wire logic       rst,
    clk_count_sec_if.slave  bus
);

    localparam int c_div   = CLK_FREQ_HZ / TICK_HZ;
    localparam int c_pre_w = $clog2(c_div);

    logic               w_clr;
    logic               w_tick;
    logic [c_pre_w-1:0] w_pre;
    time_field_t        r_secs;

    assign w_clr = bus.rst_counters | bus.set_sec_valid;

    clk_prescaler #(
        .DIV (c_div)
    ) u_prescaler (
        .CLK  (CLK),
        .rst  (rst),
        .clr  (w_clr),
        .en   (bus.run),
        .tick (w_tick),
        .pre  (w_pre)
    );

    always_ff @(posedge CLK) begin
        if (rst || bus.rst_counters) begin
            r_secs <= '0;
        end else if (bus.set_sec_valid) begin
            r_secs <= sat_sec(bus.set_sec_val);
        end else if (w_tick) begin
            r_secs <= (r_secs == SEC_MAX) ? '0 : r_secs + 8'd1;
        end
    end

    // The minutes stage samples count_up_min on the same edge that secs wraps.
    assign bus.tick_sec     = w_tick;
    assign bus.count_up_min = w_tick & (r_secs == SEC_MAX);
    assign bus.secs         = r_secs;

`ifdef CLK_SEC_BLINK_EN
    localparam logic [c_pre_w-1:0] c_half = c_pre_w'(c_div / 2);

    assign bus.blink = bus.run & ~rst & ~w_clr & (w_pre < c_half);
`else
    logic w_unused_pre;
    assign w_unused_pre = ^w_pre;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_count_sec.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_count_sec
// Brief    : Self-checking bench for clk_count_sec with DIV=8: directed
//            sequences, a load table and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_count_sec;
    import clk_pkg::*;

    localparam int DIV = 8;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    clk_count_sec_if bus();

    clk_count_sec #(
        .CLK_FREQ_HZ (8),
        .TICK_HZ     (1)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_pre = 0;
    int   m_secs = 0;
    int   n_tick_seen = 0;
    int   n_cum_seen = 0;
    logic obs_tick, obs_cum, obs_blink;
    int   obs_secs;

    typedef struct {
        int val;
        int exp_secs;
    } ld_vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rc, input logic rn,
                         input logic ld, input int val);
        rst               = r;
        bus.rst_counters  = rc;
        bus.run           = rn;
        bus.set_sec_valid = ld;
        bus.set_sec_val   = 8'(val);
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit act;
        int e_tick, e_cum, e_blink;
        @(negedge CLK);
        act     = !rst && !bus.rst_counters && !bus.set_sec_valid && bus.run;
        e_tick  = (act && m_pre == DIV - 1) ? 1 : 0;
        e_cum   = (e_tick == 1 && m_secs == 59) ? 1 : 0;
        e_blink = (act && m_pre < DIV / 2) ? 1 : 0;
        obs_tick = bus.tick_sec;
        obs_cum  = bus.count_up_min;
        obs_secs = int'(bus.secs);
`ifdef CLK_SEC_BLINK_EN
        obs_blink = bus.blink;
        chk("blink", int'(obs_blink), e_blink);
`else
        obs_blink = 1'b0;
`endif
        chk("secs", obs_secs, m_secs);
        chk("tick_sec", int'(obs_tick), e_tick);
        chk("count_up_min", int'(obs_cum), e_cum);
        if (obs_tick) n_tick_seen++;
        if (obs_cum)  n_cum_seen++;
        if (rst || bus.rst_counters) begin
            m_pre = 0; m_secs = 0;
        end else if (bus.set_sec_valid) begin
            m_pre  = 0;
            m_secs = (int'(bus.set_sec_val) > 59) ? 59 : int'(bus.set_sec_val);
        end else if (bus.run) begin
            m_pre = m_pre + 1;
            if (m_pre == DIV) begin
                m_pre  = 0;
                m_secs = (m_secs + 1) % 60;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_until_tick(input int max, output int n);
        n = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (obs_tick) begin
                n = i + 1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_vec_t tbl[6];
        int n, c0, t0, frozen;

        tbl[0] = '{0, 0};
        tbl[1] = '{30, 30};
        tbl[2] = '{59, 59};
        tbl[3] = '{60, 59};
        tbl[4] = '{75, 59};
        tbl[5] = '{255, 59};

        // Reset, then first tick latency.
        drive(1, 0, 0, 0, 0);
        step(); step();
        chk("reset_secs", obs_secs, 0);
        drive(0, 0, 1, 0, 0);
        run_until_tick(20, n);
        chk("t1_first_tick_cycle", n, DIV);
        step();
        chk("t1_secs_after_tick", obs_secs, 1);
        chk("t1_no_cum", n_cum_seen, 0);

        // Load 58 and cross the minute wrap.
        drive(0, 0, 1, 1, 58); step();
        drive(0, 0, 1, 0, 0);
        c0 = n_cum_seen; t0 = n_tick_seen;
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs_cum) chk("t2_cum_at_59", obs_secs, 59);
        end
        chk("t2_cum_count", n_cum_seen - c0, 1);
        chk("t2_tick_count", n_tick_seen - t0, 2);
        step();
        chk("t2_secs_wrapped", obs_secs, 0);

        // Load saturation table.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, tbl[i].val); step();
            drive(0, 0, 0, 0, 0);          step();
            chk("t3_load_sat", obs_secs, tbl[i].exp_secs);
        end

        // Load coinciding with the terminal prescaler count.
        drive(0, 0, 1, 1, 20); step();
        drive(0, 0, 1, 0, 0);
        repeat (7) step();
        drive(0, 0, 1, 1, 10); step();
        chk("t3_load_no_tick", int'(obs_tick), 0);
        chk("t3_load_no_cum", int'(obs_cum), 0);
        drive(0, 0, 1, 0, 0);
        run_until_tick(20, n);
        chk("t3_pre_cleared", n, DIV);

        // Hold mid-second.
        drive(0, 0, 1, 1, 0); step();
        drive(0, 0, 1, 0, 0);
        repeat (5) step();
        drive(0, 0, 0, 0, 0);
        t0 = n_tick_seen;
        step();
        frozen = obs_secs;
        repeat (19) step();
        chk("t4_no_tick_held", n_tick_seen - t0, 0);
        chk("t4_secs_frozen", obs_secs, frozen);
        drive(0, 0, 1, 0, 0);
        run_until_tick(20, n);
        chk("t4_resume_latency", n, 3);

        // rst_counters beats a load at pre==7.
        drive(0, 0, 1, 1, 59); step();
        drive(0, 0, 1, 0, 0);
        repeat (7) step();
        drive(0, 1, 1, 1, 30); step();
        chk("t5_no_tick", int'(obs_tick), 0);
        chk("t5_no_cum", int'(obs_cum), 0);
        drive(0, 0, 1, 0, 0);
        run_until_tick(20, n);
        chk("t5_pre_cleared", n, DIV);
        chk("t5_secs_cleared", obs_secs, 0);

`ifdef CLK_SEC_BLINK_EN
        drive(0, 1, 1, 0, 0); step();
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < DIV; i++) begin
            step();
            chk("t6_blink_phase", int'(obs_blink), (i < DIV / 2) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0); step();
        chk("t6_blink_hold", int'(obs_blink), 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 255)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
